// File: rtl/kmeans_sched.sv
// kmeans_sched: outer-loop iteration scheduler for the K-means pixel engine.
// It loads initial means, then repeatedly clears the engine, launches a pass,
// merges both engine banks, divides into new means and tests convergence.
// Channel c of cluster i lives at slot s = i*3+c.
// Accumulators are read at [s*AW +: AW] within a bank.
// Means are held at mean_out[s*8 +: 8], so c=2 is R, c=1 is G and c=0 is B.
// Optional build macro: KSCHED_ROUND_EN (round-half-up division instead of truncation).
module kmeans_sched #(
    parameter int K  = 16,
    parameter int AW = 24,
    parameter int CW = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            max_iter,
    input  logic [7:0]            tol,
    input  logic [K-1:0]          enabled_in,
    input  logic                  init_wr,
    input  logic [3:0]            init_idx,
    input  logic [23:0]           init_mean,
    input  logic                  pass_done,
    input  logic [2*K*3*AW-1:0]   acc_in,
    input  logic [2*K*CW-1:0]     cnt_in,
    output logic                  eng_clear,
    output logic                  pass_start,
    output logic [K*24-1:0]       mean_out,
    output logic [K-1:0]          enabled,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [7:0]            iter_count
);
    localparam int NS  = K * 3;
    localparam int SW  = $clog2(NS);
    localparam int CLW = $clog2(K);
    localparam int QW  = AW + 1;
    localparam int DW  = AW + 2;
    localparam int VW  = CW + 1;
    localparam int STW = $clog2(AW + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PASS   = 3'd2,
        WAIT   = 3'd3,
        DIVIDE = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [7:0]         max_r;
    logic [7:0]         tol_r;
    logic [7:0]         mean_r   [NS];
    logic [7:0]         shadow_r [NS];
    logic [CLW-1:0]     clu_r;
    logic [1:0]         ch_r;
    logic [STW-1:0]     step_r;
    logic [VW-1:0]      rem_r;
    logic [QW-1:0]      quo_r;
    logic [VW-1:0]      div_r;
    logic               sat_r;
    logic               skip_r;

    logic               start_ok_s;
    logic [SW-1:0]      slot_s;
    logic [AW-1:0]      acc0_s;
    logic [AW-1:0]      acc1_s;
    logic [CW-1:0]      cnt0_s;
    logic [CW-1:0]      cnt1_s;
    logic [VW-1:0]      divisor_s;
    logic [DW-1:0]      dividend_s;
    logic [VW:0]        trial_s;
    logic               ge_s;
    logic [VW-1:0]      rem_nxt_s;
    logic [QW-1:0]      quo_nxt_s;
    logic [7:0]         res8_s;
    logic               last_step_s;
    logic               last_slot_s;
    logic               conv_s;
    logic [7:0]         iter_inc_s;

    // Absolute difference of two 8-bit channel values.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // Slot selection, bank merge and one restoring-division step.
    always_comb begin
        start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));
        slot_s      = SW'((32'(clu_r) * 32'd3) + 32'(ch_r));
        acc0_s      = acc_in[slot_s*AW +: AW];
        acc1_s      = acc_in[NS*AW + slot_s*AW +: AW];
        cnt0_s      = cnt_in[clu_r*CW +: CW];
        cnt1_s      = cnt_in[K*CW + clu_r*CW +: CW];
        divisor_s   = VW'(cnt0_s) + VW'(cnt1_s);
`ifdef KSCHED_ROUND_EN
        dividend_s  = DW'(acc0_s) + DW'(acc1_s) + DW'(divisor_s[VW-1:1]);
`else
        dividend_s  = DW'(acc0_s) + DW'(acc1_s);
`endif
        trial_s     = {rem_r, quo_r[QW-1]};
        ge_s        = (trial_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_nxt_s = VW'(trial_s - {1'b0, div_r});
        end else begin
            rem_nxt_s = VW'(trial_s);
        end
        quo_nxt_s   = {quo_r[QW-2:0], ge_s};
        if (sat_r || (|quo_nxt_s[QW-1:8])) begin
            res8_s = 8'hFF;
        end else begin
            res8_s = quo_nxt_s[7:0];
        end
        last_step_s = (step_r == STW'(AW + 1));
        last_slot_s = (clu_r == CLW'(K - 1)) && (ch_r == 2'd2);
        iter_inc_s  = iter_count + 8'd1;
    end

    // Convergence test: every channel of shadow within tol of the live means.
    always_comb begin
        conv_s = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (abs_diff(shadow_r[s], mean_r[s]) > tol_r) begin
                conv_s = 1'b0;
            end else begin
                conv_s = conv_s;
            end
        end
    end

    // Next-state logic for the outer loop.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    if (start) next_s = CLEAR; else next_s = IDLE;
            CLEAR:   next_s = PASS;
            PASS:    next_s = WAIT;
            WAIT:    if (pass_done) next_s = DIVIDE; else next_s = WAIT;
            DIVIDE:  if (last_slot_s && last_step_s) next_s = CHECK; else next_s = DIVIDE;
            CHECK:   if (conv_s || (iter_inc_s == max_r)) next_s = DONE; else next_s = CLEAR;
            DONE:    if (start) next_s = CLEAR; else next_s = DONE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Control outputs registered from the next state so pulses align with their states.
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_clear  <= 1'b0;
            pass_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
        end else begin
            eng_clear  <= (next_s == CLEAR);
            pass_start <= (next_s == PASS);
            busy       <= (next_s != IDLE) && (next_s != DONE);
            done       <= (next_s == DONE);
            if (state_r == CHECK) begin
                converged <= conv_s;
            end else if (next_s != DONE) begin
                converged <= 1'b0;
            end else begin
                converged <= converged;
            end
        end
    end

    // Run parameters latched on an accepted start; iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            enabled    <= {K{1'b0}};
            max_r      <= 8'd0;
            tol_r      <= 8'd0;
            iter_count <= 8'd0;
        end else if (start_ok_s) begin
            enabled    <= enabled_in;
            max_r      <= (max_iter == 8'd0) ? 8'd1 : max_iter;
            tol_r      <= tol;
            iter_count <= 8'd0;
        end else if (state_r == CHECK) begin
            iter_count <= iter_inc_s;
        end else begin
            iter_count <= iter_count;
        end
    end

    // Sequencer and restoring divider: one load cycle then AW+1 quotient bits per slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            clu_r  <= {CLW{1'b0}};
            ch_r   <= 2'd0;
            step_r <= {STW{1'b0}};
            rem_r  <= {VW{1'b0}};
            quo_r  <= {QW{1'b0}};
            div_r  <= {VW{1'b0}};
            sat_r  <= 1'b0;
            skip_r <= 1'b0;
        end else if (state_r == DIVIDE) begin
            if (step_r == {STW{1'b0}}) begin
                rem_r  <= {VW{1'b0}};
                quo_r  <= dividend_s[QW-1:0];
                div_r  <= divisor_s;
                // A carry out of the rounded sum already implies a quotient far above 255.
                sat_r  <= dividend_s[DW-1];
                skip_r <= !enabled[clu_r] || (divisor_s == {VW{1'b0}});
                step_r <= STW'(1);
            end else begin
                rem_r <= rem_nxt_s;
                quo_r <= quo_nxt_s;
                if (last_step_s) begin
                    step_r <= {STW{1'b0}};
                    if (ch_r == 2'd2) begin
                        ch_r <= 2'd0;
                        if (last_slot_s) begin
                            clu_r <= {CLW{1'b0}};
                        end else begin
                            clu_r <= clu_r + CLW'(1);
                        end
                    end else begin
                        ch_r <= ch_r + 2'd1;
                    end
                end else begin
                    step_r <= step_r + STW'(1);
                end
            end
        end else begin
            clu_r  <= {CLW{1'b0}};
            ch_r   <= 2'd0;
            step_r <= {STW{1'b0}};
        end
    end

    // Means and shadow: init writes in IDLE, shadow fill in DIVIDE, atomic copy in CHECK.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                mean_r[s]   <= 8'd0;
                shadow_r[s] <= 8'd0;
            end
        end else if ((state_r == IDLE) && init_wr && (32'(init_idx) < K)) begin
            for (int c = 0; c < 3; c++) begin
                mean_r[SW'((32'(init_idx) * 32'd3) + 32'(c))] <= init_mean[c*8 +: 8];
            end
        end else if ((state_r == DIVIDE) && last_step_s) begin
            if (skip_r) begin
                shadow_r[slot_s] <= mean_r[slot_s];
            end else begin
                shadow_r[slot_s] <= res8_s;
            end
        end else if (state_r == CHECK) begin
            for (int s = 0; s < NS; s++) begin
                mean_r[s] <= shadow_r[s];
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                mean_r[s] <= mean_r[s];
            end
        end
    end

    // Flatten the live means onto the engine-facing bus.
    always_comb begin
        mean_out = {(K*24){1'b0}};
        for (int s = 0; s < NS; s++) begin
            mean_out[s*8 +: 8] = mean_r[s];
        end
    end

endmodule

// File: tb/tb_kmeans_sched.sv
// tb_kmeans_sched: directed and randomized bench for kmeans_sched with an
// arithmetic reference model of one clustering iteration.
`timescale 1ns/1ps
module tb_kmeans_sched;
    localparam int K  = 16;
    localparam int AW = 24;
    localparam int CW = 12;
    localparam int NS = K * 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [7:0]          max_iter;
    logic [7:0]          tol;
    logic [K-1:0]        enabled_in;
    logic                init_wr;
    logic [3:0]          init_idx;
    logic [23:0]         init_mean;
    logic                pass_done;
    logic [2*K*3*AW-1:0] acc_in;
    logic [2*K*CW-1:0]   cnt_in;
    logic                eng_clear;
    logic                pass_start;
    logic [K*24-1:0]     mean_out;
    logic [K-1:0]        enabled;
    logic                busy;
    logic                done;
    logic                converged;
    logic [7:0]          iter_count;

    kmeans_sched #(.K(K), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .tol(tol),
        .enabled_in(enabled_in), .init_wr(init_wr), .init_idx(init_idx),
        .init_mean(init_mean), .pass_done(pass_done), .acc_in(acc_in), .cnt_in(cnt_in),
        .eng_clear(eng_clear), .pass_start(pass_start), .mean_out(mean_out),
        .enabled(enabled), .busy(busy), .done(done), .converged(converged),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // reference model state
    int          m  [NS];
    int          a0 [NS];
    int          a1 [NS];
    int          c0 [K];
    int          c1 [K];
    logic [15:0] en_m;
    int          tol_m;
    int          maxeff_m;
    int          iter_m;
    bit          conv_m;
    bit          final_m;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkm(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] exp_means();
        logic [383:0] r;
        r = 384'd0;
        for (int s = 0; s < NS; s++) r[s*8 +: 8] = 8'(m[s]);
        return r;
    endfunction

    task automatic clear_acc();
        for (int s = 0; s < NS; s++) begin a0[s] = 0; a1[s] = 0; end
        for (int i = 0; i < K; i++) begin c0[i] = 0; c1[i] = 0; end
    endtask

    task automatic apply_acc();
        for (int s = 0; s < NS; s++) begin
            acc_in[s*AW +: AW]         = AW'(a0[s]);
            acc_in[NS*AW + s*AW +: AW] = AW'(a1[s]);
        end
        for (int i = 0; i < K; i++) begin
            cnt_in[i*CW +: CW]        = CW'(c0[i]);
            cnt_in[K*CW + i*CW +: CW] = CW'(c1[i]);
        end
    endtask

    task automatic rand_acc();
        for (int i = 0; i < K; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                c0[i] = 0; c1[i] = 0;
            end else begin
                c0[i] = int'($urandom_range(0, 4095));
                c1[i] = int'($urandom_range(0, 4095));
            end
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    a0[i*3+c] = int'($urandom_range(0, 16777215));
                    a1[i*3+c] = int'($urandom_range(0, 16777215));
                end else begin
                    a0[i*3+c] = c0[i] * int'($urandom_range(0, 300)) + int'($urandom_range(0, c0[i]));
                    a1[i*3+c] = c1[i] * int'($urandom_range(0, 300)) + int'($urandom_range(0, c1[i]));
                end
            end
        end
        apply_acc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int s = 0; s < NS; s++) m[s] = 0;
        iter_m = 0;
    endtask

    task automatic init_w(input int idx, input logic [23:0] val, input bit honoured);
        init_wr = 1'b1; init_idx = 4'(idx); init_mean = val;
        tick(1);
        init_wr = 1'b0;
        if (honoured) begin
            for (int c = 0; c < 3; c++) m[idx*3+c] = int'(val[c*8 +: 8]);
        end
    endtask

    task automatic do_start(input logic [15:0] en, input logic [7:0] mi, input logic [7:0] t);
        start = 1'b1; enabled_in = en; max_iter = mi; tol = t;
        tick(1);
        start = 1'b0;
        en_m = en; maxeff_m = (mi == 8'd0) ? 1 : int'(mi); tol_m = int'(t); iter_m = 0;
        chk1("start_eng_clear", eng_clear, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk1("start_done", done, 1'b0);
        chk8("start_iter", iter_count, 8'd0);
        chkm("start_enabled", 384'(enabled), 384'(en));
    endtask

    // One iteration of the algorithm, computed directly from the rules.
    task automatic model_pass();
        int     nm [NS];
        longint num;
        longint dv;
        longint q;
        int     d;
        conv_m = 1'b1;
        for (int s = 0; s < NS; s++) begin
            dv = longint'(c0[s/3]) + longint'(c1[s/3]);
            if (en_m[s/3] && dv != 0) begin
                num = longint'(a0[s]) + longint'(a1[s]);
`ifdef KSCHED_ROUND_EN
                num = num + dv / 2;
`endif
                q = num / dv;
                if (q > 255) q = 255;
                nm[s] = int'(q);
            end else begin
                nm[s] = m[s];
            end
            d = (nm[s] > m[s]) ? nm[s] - m[s] : m[s] - nm[s];
            if (d > tol_m) conv_m = 1'b0;
        end
        for (int s = 0; s < NS; s++) m[s] = nm[s];
        iter_m++;
        final_m = conv_m || (iter_m == maxeff_m);
    endtask

    // Entered at the negedge where eng_clear is high; returns where the next
    // eng_clear or done is first visible.
    task automatic do_pass(input int dly, input bit inj_wr, input bit inj_start);
        int           k;
        logic [383:0] old;
        tick(1);
        chk1("pass_start", pass_start, 1'b1);
        chk1("eng_clear_pulse", eng_clear, 1'b0);
        if (inj_wr) begin init_wr = 1'b1; init_idx = 4'd5; init_mean = 24'hABCDEF; end
        tick(dly);
        init_wr = 1'b0;
        old = exp_means();
        pass_done = 1'b1;
        tick(1);
        pass_done = 1'b0;
        k = 1;
        while (!(eng_clear === 1'b1 || done === 1'b1) && k < 3000) begin
            if (k == 1249) chkm("mean_hold", mean_out, old);
            start = inj_start && (k == 100);
            tick(1);
            start = 1'b0;
            k++;
        end
        chki("pass_to_next_latency", k, 1250);
        model_pass();
        chkm("means", mean_out, exp_means());
        chk8("iter_count", iter_count, 8'(iter_m));
        chk1("done", done, final_m);
        chk1("busy", busy, !final_m);
        chk1("eng_clear_next", eng_clear, !final_m);
        if (final_m) chk1("converged", converged, conv_m);
    endtask

    initial begin
        int          np;
        logic [15:0] ren;
        reset = 1'b0; start = 1'b0; max_iter = 8'd0; tol = 8'd0; enabled_in = 16'd0;
        init_wr = 1'b0; init_idx = 4'd0; init_mean = 24'd0; pass_done = 1'b0;
        acc_in = '0; cnt_in = '0;
        clear_acc();
        en_m = 16'd0; tol_m = 0; maxeff_m = 1; conv_m = 1'b0; final_m = 1'b0;

        // reset state
        do_reset();
        chk1("rst_eng_clear", eng_clear, 1'b0);
        chk1("rst_pass_start", pass_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkm("rst_means", mean_out, 384'd0);

        // reset held two cycles in the middle of WAIT
        init_w(3, 24'h123456, 1'b1);
        chkm("init_write", mean_out, exp_means());
        do_start(16'hFFFF, 8'd4, 8'd0);
        tick(3);
        do_reset();
        chk1("midrst_eng_clear", eng_clear, 1'b0);
        chk1("midrst_pass_start", pass_start, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_converged", converged, 1'b0);
        chk8("midrst_iter", iter_count, 8'd0);
        chkm("midrst_enabled", 384'(enabled), 384'd0);
        chkm("midrst_means", mean_out, 384'd0);

        // single division on cluster 0 R
        clear_acc();
        a0[2] = 600; a1[2] = 403; c0[0] = 3; c1[0] = 2;
        apply_acc();
        do_start(16'h0003, 8'd1, 8'd0);
        do_pass(5, 1'b0, 1'b0);
`ifdef KSCHED_ROUND_EN
        chk8("single_R", mean_out[23:16], 8'd201);
`else
        chk8("single_R", mean_out[23:16], 8'd200);
`endif
        chk1("single_done", done, 1'b1);
        chk1("single_conv", converged, 1'b0);
        chk8("single_iter", iter_count, 8'd1);

        // convergence on the second iteration
        do_reset();
        clear_acc();
        a0[0] = 1000; a0[1] = 1000; a0[2] = 1000; c0[0] = 5;
        apply_acc();
        do_start(16'h0001, 8'd10, 8'd0);
        do_pass(2, 1'b0, 1'b0);
        do_pass(1, 1'b0, 1'b0);
        chk1("conv_flag", converged, 1'b1);
        chk8("conv_iter", iter_count, 8'd2);
        chk8("conv_R", mean_out[23:16], 8'd200);

        // iteration limit with changing accumulators
        do_reset();
        clear_acc();
        c0[0] = 5; a0[2] = 500;
        apply_acc();
        do_start(16'h0001, 8'd3, 8'd0);
        do_pass(3, 1'b0, 1'b0);
        a0[2] = 1000; apply_acc();
        do_pass(1, 1'b0, 1'b0);
        a0[2] = 1500; apply_acc();
        do_pass(2, 1'b0, 1'b0);
        chk1("limit_conv", converged, 1'b0);
        chk8("limit_iter", iter_count, 8'd3);

        // empty cluster 1, disabled cluster 2, saturating cluster 3 channel 0
        do_reset();
        rand_acc();
        c0[1] = 0; c1[1] = 0;
        c0[2] = 7; c1[2] = 9;
        c0[3] = 2; c1[3] = 2; a0[9] = 16777215; a1[9] = 16777215;
        apply_acc();
        init_w(1, 24'h102030, 1'b1);
        init_w(2, 24'h405060, 1'b1);
        do_start(16'hFFFB, 8'd1, 8'd0);
        do_pass(4, 1'b0, 1'b0);
        chkm("empty_cluster", 384'(mean_out[1*24 +: 24]), 384'(24'h102030));
        chkm("disabled_cluster", 384'(mean_out[2*24 +: 24]), 384'(24'h405060));
        chk8("saturate", mean_out[9*8 +: 8], 8'd255);

        // init_wr during PASS/WAIT and start during DIVIDE are ignored
        do_reset();
        rand_acc();
        do_start(16'hFFDF, 8'd2, 8'd0);
        do_pass(3, 1'b1, 1'b0);
        if (!final_m) begin
            rand_acc();
            do_pass(2, 1'b0, 1'b1);
        end
        chkm("ignored_init", 384'(mean_out[5*24 +: 24]), 384'd0);

        // randomized runs; later runs restart from DONE with the current means
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin
                do_reset();
                for (int i = 0; i < K; i++) init_w(i, 24'($urandom), 1'b1);
                chkm("rand_init", mean_out, exp_means());
            end else begin
                init_w(r, 24'($urandom), 1'b0);
                chkm("done_init_ignored", mean_out, exp_means());
            end
            ren = 16'($urandom);
            do_start(ren, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 10)));
            np = 0;
            do begin
                rand_acc();
                do_pass(int'($urandom_range(1, 6)), 1'b0, 1'b0);
                np++;
            end while (!final_m && np < 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
